// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - read-side consumer of the async FIFO with a 2-entry valid/ready output buffer
//
// Purpose: issues FIFO reads only when the word is guaranteed a buffer slot,
// captures the registered FIFO read data one cycle later, and presents it as a
// valid/ready stream with burst framing and a popped-word counter.
//
// Ports:
//   clk_r       read-domain clock
//   rst         asynchronous active-high reset
//   en          allow new FIFO reads (buffered/in-flight words always drain)
//   fifo_empty  FIFO empty flag
//   fifo_rdata  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  FIFO read strobe
//   m_valid     output word available
//   m_ready     downstream accepts the word
//   m_data      head word of the output buffer
//   m_last      head word closes a burst of BURST_LEN words
//   word_cnt    words popped since reset, wraps
//   busy        read in flight or buffer non-empty
module fifo_rd_stream #(
  parameter int WIDTH     = 16,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk_r,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy
);

  localparam int BI_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BI_W-1:0] BIDX_LAST = BI_W'(BURST_LEN - 1);

  logic [1:0]       occ;
  logic             infl;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [BI_W-1:0]  bidx;
  logic             pop;
  logic [1:0]       occ_after;

  assign pop = m_valid & m_ready;

  // Occupancy once this cycle's capture and pop have settled. A new read is
  // only issued if its word will still find a free slot when it lands, so the
  // buffer can never overflow.
  assign occ_after = occ + {1'b0, infl} - {1'b0, pop};

  // Gated by rst so the strobe is low for the whole reset, even though the
  // cleared occupancy would otherwise already permit a read.
  assign fifo_rd_en = ~rst & en & ~fifo_empty & (occ_after <= 2'd1);

  assign m_valid = (occ != 2'd0);
  assign m_data  = head;
  assign m_last  = m_valid & (bidx == BIDX_LAST);
  assign busy    = infl | m_valid;

  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      infl     <= 1'b0;
      head     <= '0;
      tail     <= '0;
      bidx     <= '0;
      word_cnt <= '0;
    end else begin
      infl <= fifo_rd_en;
      occ  <= occ_after;

      case ({infl, pop})
        2'b10: begin
          if (occ == 2'd0) head <= fifo_rdata;
          else             tail <= fifo_rdata;
        end
        2'b01: begin
          head <= tail;
        end
        2'b11: begin
          // With one word held the captured word replaces it directly;
          // with two, the tail moves up and the new word takes its place.
          if (occ == 2'd1) begin
            head <= fifo_rdata;
          end else begin
            head <= tail;
            tail <= fifo_rdata;
          end
        end
        default: ;
      endcase

      if (pop) begin
        word_cnt <= word_cnt + CNT_W'(1);
        if (bidx == BIDX_LAST) bidx <= '0;
        else                   bidx <= bidx + BI_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

  localparam int W  = 16;
  localparam int BL = 4;

  logic          clk_r = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_empty;
  logic [W-1:0]  fifo_rdata;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic [15:0]   word_cnt;
  logic          busy;

  fifo_rd_stream #(.WIDTH(W), .BURST_LEN(BL), .CNT_W(16)) dut (
    .clk_r      (clk_r),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .word_cnt   (word_cnt),
    .busy       (busy)
  );

  always #5 clk_r = ~clk_r;

  // Behavioural model: the FIFO is a queue, the DUT's buffer is a queue of
  // captured words, and the stream is the FIFO contents in write order.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] bq[$];
  logic [W-1:0] rdata_reg;
  logic [W-1:0] wr_seq;
  logic [W-1:0] exp_seq;
  logic         infl_m;
  int           npop;
  bit           underflow;
  int           cyc;
  int           checks;
  int           failures;
  int           rd_pulses;
  int           first_valid;
  logic [W-1:0] pop_d[$];
  int           pop_c[$];
  bit           pop_l[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(wr_seq);
      wr_seq = wr_seq + 1'b1;
    end
  endtask

  task automatic clear_rec();
    pop_d.delete();
    pop_c.delete();
    pop_l.delete();
    rd_pulses   = 0;
    first_valid = -1;
  endtask

  // One clock: present FIFO-side inputs, check every output at the negedge
  // against the model, then advance the model past the rising edge.
  task automatic cycle();
    int sz;
    bit ev, ep, er, s_rd;
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = rdata_reg;
    @(negedge clk_r);
    sz = bq.size();
    ev = (sz > 0);
    ep = ev && m_ready;
    er = en && !fifo_empty && ((sz + int'(infl_m) - int'(ep)) <= 1);
    chk("m_valid", m_valid, ev);
    chk("fifo_rd_en", fifo_rd_en, er);
    chk("busy", busy, infl_m || ev);
    chk("word_cnt", word_cnt, npop[15:0]);
    chk("m_last", m_last, ev && ((npop % BL) == BL - 1));
    if (ev) chk("m_data", m_data, bq[0]);
    if (ep) begin
      chk("pop_order", m_data, exp_seq);
      exp_seq = exp_seq + 1'b1;
      pop_d.push_back(m_data);
      pop_c.push_back(cyc);
      pop_l.push_back(m_last);
    end
    if (fifo_rd_en) rd_pulses++;
    if (fifo_rd_en && fifo_empty) underflow = 1'b1;
    if (m_valid && first_valid < 0) first_valid = cyc;
    s_rd = fifo_rd_en;
    @(posedge clk_r);
    #1;
    if (ep) begin
      void'(bq.pop_front());
      npop++;
    end
    if (infl_m) bq.push_back(rdata_reg);
    infl_m = s_rd;
    if (s_rd && fifo_q.size() > 0) rdata_reg = fifo_q.pop_front();
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bq.delete();
    fifo_q.delete();
    infl_m     = 1'b0;
    npop       = 0;
    rdata_reg  = '0;
    fifo_rdata = '0;
    fifo_empty = 1'b1;
    wr_seq     = 16'd1;
    exp_seq    = 16'd1;
    repeat (2) @(posedge clk_r);
    #1 rst = 1'b0;
  endtask

  task automatic run_pops(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (pop_d.size() >= target) break;
      cycle();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int first_last;
    checks = 0; failures = 0; cyc = 0; underflow = 1'b0;
    rst = 1'b0; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_rdata = '0;
    infl_m = 1'b0; npop = 0; rdata_reg = '0; wr_seq = 16'd1; exp_seq = 16'd1;
    clear_rec();

    // Reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_fifo_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    // Empty FIFO with en high: no reads, no output
    en = 1'b1; m_ready = 1'b1; clear_rec();
    repeat (20) cycle();
    chk("t1_rd_pulses", rd_pulses, 0);
    chk("t1_first_valid", first_valid, -1);
    chk("t1_underflow", underflow, 0);

    // 8 preloaded words, m_ready high
    do_reset();
    en = 1'b1; m_ready = 1'b1; clear_rec();
    push(8);
    c0 = cyc;
    run_pops(8, 40);
    chk("t2_pop_count", pop_d.size(), 8);
    chk("t2_first_valid_lat", first_valid - c0, 2);
    if (pop_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t2_data", pop_d[i], i + 1);
        chk("t2_consecutive", pop_c[i] - pop_c[0], i);
        chk("t2_last", pop_l[i], (i == 3 || i == 7));
      end
    end
    chk("t2_word_cnt", word_cnt, 8);

    // Stall with m_ready low, then release
    do_reset();
    en = 1'b1; m_ready = 1'b0; clear_rec();
    push(8);
    repeat (10) cycle();
    chk("t3_rd_pulses", rd_pulses, 2);
    chk("t3_m_valid", m_valid, 1);
    chk("t3_m_data_held", m_data, 16'h0001);
    m_ready = 1'b1;
    run_pops(8, 40);
    chk("t3_pop_count", pop_d.size(), 8);
    chk("t3_word_cnt", word_cnt, 8);

    // Random writer, random m_ready and en, 1000 words
    do_reset();
    clear_rec();
    for (int i = 0; i < 8000; i++) begin
      if (pop_d.size() >= 1000) break;
      if (wr_seq <= 16'd1000 && fifo_q.size() < 16 && ($urandom % 2) != 0) push(1);
      m_ready = ($urandom % 2) != 0;
      en      = ($urandom % 8) != 0;
      cycle();
    end
    chk("rand_pop_count", pop_d.size(), 1000);
    chk("rand_underflow", underflow, 0);

    // Asynchronous reset with a full buffer
    do_reset();
    clear_rec();
    en = 1'b1; m_ready = 1'b0;
    push(8);
    repeat (4) cycle();
    chk("ar_pre_valid", m_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_fifo_rd_en", fifo_rd_en, 0);
    chk("ar_m_valid", m_valid, 0);
    chk("ar_m_data", m_data, 0);
    chk("ar_m_last", m_last, 0);
    chk("ar_word_cnt", word_cnt, 0);
    chk("ar_busy", busy, 0);
    do_reset();
    clear_rec();
    en = 1'b1; m_ready = 1'b1;
    push(8);
    run_pops(8, 40);
    first_last = -1;
    for (int i = 0; i < pop_l.size(); i++) begin
      if (pop_l[i] && first_last < 0) first_last = i;
    end
    chk("ar_first_last_idx", first_last, 3);

    // Counter wrap over 65537 pops, then en low and drain
    do_reset();
    clear_rec();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      if (npop >= 65537) break;
      if (fifo_q.size() < 4) push(1);
      cycle();
    end
    chk("wrap_npop", npop, 65537);
    chk("wrap_word_cnt", word_cnt, 16'h0001);
    en = 1'b0;
    rd_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (!busy) break;
    end
    chk("drain_rd_pulses", rd_pulses, 0);
    chk("drain_busy", busy, 0);
    chk("drain_m_valid", m_valid, 0);
    chk("final_underflow", underflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
